// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush control for a 5-stage pipeline with memory-wait watchdog
module pipeline_hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_valid,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_hold,
    output logic [1:0]       state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2} state_t;
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic             active, load_use, mem_stall, stall_inc, flush_inc;

    // Hazard detection and prioritized pipeline-control decode
    always_comb begin
        active    = (state_q == RUN) || (state_q == MEM_WAIT);
        load_use  = ex_valid && ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        mem_stall = (state_q == RUN) ? (mem_req && !mem_ready) :
                    (state_q == MEM_WAIT) ? !mem_ready : 1'b0;
        stall_inc = active && (mem_stall || (!ex_branch_taken && load_use));
        flush_inc = active && !mem_stall && ex_branch_taken;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_hold  = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (!active) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            ex_mem_hold  = 1'b1;
        end else if (mem_stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            ex_mem_hold  = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // Next-state logic for the memory-wait FSM, watchdog and saturating counters
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        stall_cnt_d   = (stall_inc && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d   = (flush_inc && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WC_W'(MEM_TIMEOUT)) begin
                    state_d       = ERROR;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            default: state_d = ERROR;
        endcase
    end

    // State and counter registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign state       = state_q;
    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of hazard decode, memory wait, watchdog and counters
module tb_pipeline_hazard_ctrl;
    localparam int REG_W = 5;
    localparam int CNT_W = 4;
    localparam int MEM_TIMEOUT = 4;
    localparam logic [4:0] C_NORM = 5'b11000, C_MEM = 5'b00001, C_BR = 5'b11110,
                           C_LU = 5'b00010, C_ERR = 5'b00011, C_RST = 5'b00110;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs1, id_uses_rs2, ex_valid, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold, mem_timeout;
    logic [1:0] state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [4:0] ctl;
    int n_checks = 0;
    int n_fail = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    int lu_tab [7][8];

    pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write),
        .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .ex_mem_hold(ex_mem_hold), .state(state), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;
    assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_valid = 0; ex_rd = '0; ex_mem_read = 0; ex_branch_taken = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    task automatic test_reset();
        idle();
        tick(); tick();
        n_checks++;
        if (ctl !== C_RST) begin n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, C_RST); end
        n_checks++;
        if (state !== 2'd0 || stall_cnt !== 0 || flush_cnt !== 0 || mem_timeout !== 1'b0) begin
            n_fail++; $display("FAIL reset_regs: state=%0d stall=%0d flush=%0d to=%b want 0 0 0 0", state, stall_cnt, flush_cnt, mem_timeout);
        end
        rst = 0;
        #1;
        n_checks++;
        if (ctl !== C_NORM) begin n_fail++; $display("FAIL reset_release_ctl: got %b want %b", ctl, C_NORM); end
    endtask

    task automatic test_load_use();
        lu_tab = '{'{3,5,1,1,1,5,1,1}, '{7,0,1,0,1,7,1,1}, '{7,0,0,0,1,7,1,0},
                   '{0,0,1,1,1,0,1,0}, '{9,0,1,0,1,9,0,0}, '{9,0,1,0,0,9,1,0},
                   '{1,9,1,0,1,9,1,0}};
        for (int i = 0; i < 7; i++) begin
            id_rs1 = REG_W'(lu_tab[i][0]); id_rs2 = REG_W'(lu_tab[i][1]);
            id_uses_rs1 = lu_tab[i][2][0]; id_uses_rs2 = lu_tab[i][3][0];
            ex_valid = lu_tab[i][4][0]; ex_rd = REG_W'(lu_tab[i][5]); ex_mem_read = lu_tab[i][6][0];
            #1;
            n_checks++;
            if (ctl !== (lu_tab[i][7] != 0 ? C_LU : C_NORM)) begin
                n_fail++; $display("FAIL load_use_ctl[%0d]: got %b want %b", i, ctl, lu_tab[i][7] != 0 ? C_LU : C_NORM);
            end
            tick();
            if (lu_tab[i][7] != 0) exp_stall++;
            n_checks++;
            if (stall_cnt !== CNT_W'(exp_stall)) begin n_fail++; $display("FAIL load_use_cnt[%0d]: got %0d want %0d", i, stall_cnt, exp_stall); end
        end
        idle();
    endtask

    task automatic test_branch();
        for (int i = 0; i < 2; i++) begin
            ex_branch_taken = 1;
            ex_valid = (i == 0); ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
            #1;
            n_checks++;
            if (ctl !== C_BR) begin n_fail++; $display("FAIL branch_ctl[%0d]: got %b want %b", i, ctl, C_BR); end
            tick();
            exp_flush++;
            n_checks++;
            if (flush_cnt !== CNT_W'(exp_flush) || stall_cnt !== CNT_W'(exp_stall)) begin
                n_fail++; $display("FAIL branch_cnt[%0d]: flush=%0d stall=%0d want %0d %0d", i, flush_cnt, stall_cnt, exp_flush, exp_stall);
            end
        end
        idle();
    endtask

    task automatic test_mem_wait();
        mem_req = 1; mem_ready = 1;
        #1;
        n_checks++;
        if (ctl !== C_NORM) begin n_fail++; $display("FAIL mem_single_ctl: got %b want %b", ctl, C_NORM); end
        tick();
        n_checks++;
        if (state !== 2'd0) begin n_fail++; $display("FAIL mem_single_state: got %0d want 0", state); end
        mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (ctl !== C_MEM) begin n_fail++; $display("FAIL mem_wait_ctl[%0d]: got %b want %b", i, ctl, C_MEM); end
            tick();
            exp_stall++;
            n_checks++;
            if (state !== 2'd1 || stall_cnt !== CNT_W'(exp_stall)) begin
                n_fail++; $display("FAIL mem_wait_state[%0d]: state=%0d stall=%0d want 1 %0d", i, state, stall_cnt, exp_stall);
            end
        end
        mem_ready = 1;
        #1;
        n_checks++;
        if (ctl !== C_NORM) begin n_fail++; $display("FAIL mem_release_ctl: got %b want %b", ctl, C_NORM); end
        tick();
        n_checks++;
        if (state !== 2'd0 || stall_cnt !== CNT_W'(exp_stall)) begin
            n_fail++; $display("FAIL mem_release_state: state=%0d stall=%0d want 0 %0d", state, stall_cnt, exp_stall);
        end
        idle();
    endtask

    task automatic test_mem_wait_branch();
        ex_branch_taken = 1; mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (ctl !== C_MEM) begin n_fail++; $display("FAIL memb_wait_ctl[%0d]: got %b want %b", i, ctl, C_MEM); end
            tick();
            exp_stall++;
            n_checks++;
            if (flush_cnt !== CNT_W'(exp_flush) || stall_cnt !== CNT_W'(exp_stall)) begin
                n_fail++; $display("FAIL memb_wait_cnt[%0d]: flush=%0d stall=%0d want %0d %0d", i, flush_cnt, stall_cnt, exp_flush, exp_stall);
            end
        end
        mem_ready = 1;
        #1;
        n_checks++;
        if (ctl !== C_BR) begin n_fail++; $display("FAIL memb_release_ctl: got %b want %b", ctl, C_BR); end
        tick();
        exp_flush++;
        n_checks++;
        if (flush_cnt !== CNT_W'(exp_flush) || state !== 2'd0) begin
            n_fail++; $display("FAIL memb_release_cnt: flush=%0d state=%0d want %0d 0", flush_cnt, state, exp_flush);
        end
        idle();
    endtask

    task automatic test_reset_midrun();
        n_checks++;
        if (stall_cnt !== 4'd7) begin n_fail++; $display("FAIL midrun_pre_cnt: got %0d want 7", stall_cnt); end
        mem_req = 1; mem_ready = 0;
        #1;
        rst = 1;
        #1;
        n_checks++;
        if (ctl !== C_RST || state !== 2'd0 || stall_cnt !== 0 || flush_cnt !== 0) begin
            n_fail++; $display("FAIL midrun_reset: ctl=%b state=%0d stall=%0d flush=%0d want %b 0 0 0", ctl, state, stall_cnt, flush_cnt, C_RST);
        end
        tick();
        rst = 0;
        tick(); tick();
        n_checks++;
        if (state !== 2'd1) begin n_fail++; $display("FAIL midwait_pre_state: got %0d want 1", state); end
        rst = 1;
        #1;
        n_checks++;
        if (state !== 2'd0 || ctl !== C_RST || stall_cnt !== 0) begin
            n_fail++; $display("FAIL midwait_reset: state=%0d ctl=%b stall=%0d want 0 %b 0", state, ctl, stall_cnt, C_RST);
        end
        idle();
        tick();
        rst = 0;
        exp_stall = 0; exp_flush = 0;
    endtask

    task automatic test_saturation();
        ex_valid = 1; ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_uses_rs1 = 1;
        for (int i = 0; i < 17; i++) tick();
        n_checks++;
        if (stall_cnt !== 4'd15 || ctl !== C_LU) begin
            n_fail++; $display("FAIL stall_saturate: cnt=%0d ctl=%b want 15 %b", stall_cnt, ctl, C_LU);
        end
        ex_branch_taken = 1;
        for (int i = 0; i < 17; i++) tick();
        n_checks++;
        if (flush_cnt !== 4'd15 || stall_cnt !== 4'd15) begin
            n_fail++; $display("FAIL flush_saturate: flush=%0d stall=%0d want 15 15", flush_cnt, stall_cnt);
        end
        idle();
    endtask

    task automatic test_timeout();
        rst = 1;
        tick();
        rst = 0;
        mem_req = 1; mem_ready = 0;
        for (int i = 1; i <= 5; i++) begin
            #1;
            n_checks++;
            if (ctl !== C_MEM) begin n_fail++; $display("FAIL timeout_wait_ctl[%0d]: got %b want %b", i, ctl, C_MEM); end
            tick();
            n_checks++;
            if (state !== (i == 5 ? 2'd2 : 2'd1) || mem_timeout !== (i == 5) || stall_cnt !== CNT_W'(i)) begin
                n_fail++; $display("FAIL timeout_state[%0d]: state=%0d to=%b stall=%0d want %0d %b %0d", i, state, mem_timeout, stall_cnt, i == 5 ? 2 : 1, i == 5, i);
            end
        end
        mem_ready = 1; ex_branch_taken = 1;
        #1;
        n_checks++;
        if (ctl !== C_ERR) begin n_fail++; $display("FAIL error_ctl: got %b want %b", ctl, C_ERR); end
        tick();
        n_checks++;
        if (state !== 2'd2 || mem_timeout !== 1'b1 || stall_cnt !== 4'd5 || flush_cnt !== 0 || ctl !== C_ERR) begin
            n_fail++; $display("FAIL error_hold: state=%0d to=%b stall=%0d flush=%0d ctl=%b want 2 1 5 0 %b", state, mem_timeout, stall_cnt, flush_cnt, ctl, C_ERR);
        end
        rst = 1;
        #1;
        n_checks++;
        if (state !== 2'd0 || mem_timeout !== 1'b0 || ctl !== C_RST) begin
            n_fail++; $display("FAIL error_reset: state=%0d to=%b ctl=%b want 0 0 %b", state, mem_timeout, ctl, C_RST);
        end
        idle();
        tick();
        rst = 0;
        #1;
        n_checks++;
        if (ctl !== C_NORM || state !== 2'd0) begin
            n_fail++; $display("FAIL error_recover: ctl=%b state=%0d want %b 0", ctl, state, C_NORM);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_mem_wait_branch();
        test_reset_midrun();
        test_saturation();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It drives the write-enable and flush controls of the PC register, the IF/ID register and the ID/EX register, and the hold control of EX/MEM. It detects load-use hazards, squashes wrong-path instructions on taken branches and freezes the pipeline during multi-cycle data-memory accesses, with a timeout watchdog. It keeps saturating stall and flush performance counters.

Parameters:
REG_W, 5, register index width
CNT_W, 32, performance counter width
MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before error (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset
id_rs1  in  REG_W  source reg 1 of instruction in ID
id_rs2  in  REG_W  source reg 2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_valid  in  1  EX holds a valid instruction
ex_rd  in  REG_W  destination reg of EX instruction
ex_mem_read  in  1  EX instruction is a load
ex_branch_taken  in  1  branch/jump resolved taken in EX
mem_req  in  1  MEM stage issues a data access this cycle
mem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC register update enable
if_id_write  out  1  IF/ID register load enable
if_id_flush  out  1  IF/ID clear to NOP (wins over if_id_write)
id_ex_bubble  out  1  ID/EX loads NOP instead of ID output
ex_mem_hold  out  1  EX/MEM and MEM/WB keep their contents
state  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 ERROR
mem_timeout  out  1  sticky watchdog error
stall_cnt  out  CNT_W  count of stall cycles
flush_cnt  out  CNT_W  count of taken-branch flushes

Behaviour:
- Reset (rst is asynchronous, active-high; clock is clk): state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0, mem_timeout=0. While rst=1, outputs are pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, ex_mem_hold=0. Reset asserted mid-stall aborts the wait immediately.
- load_use = ex_valid & ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- mem_stall = mem_req & ~mem_ready in RUN; in MEM_WAIT, mem_stall = ~mem_ready.
- Output decode is combinational from state and inputs, evaluated in strict priority order:
  1. mem_stall: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=0, ex_mem_hold=1. A branch or load-use in the same cycle is ignored, because EX is frozen and the condition re-presents itself later.
  2. ex_branch_taken: pc_write=1 (redirect target), if_id_write=1, if_id_flush=1, id_ex_bubble=1, ex_mem_hold=0. The ID instruction is squashed, so no load-use stall applies.
  3. load_use: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1, ex_mem_hold=0. Exactly one bubble is inserted; the next cycle the load is in MEM and load_use deasserts.
  4. Otherwise: pc_write=1, if_id_write=1, all others 0.
- FSM transitions:
  - RUN to MEM_WAIT when mem_req & ~mem_ready; wait_cnt<=1.
  - RUN stays in RUN on a single-cycle access (mem_req & mem_ready).
  - MEM_WAIT to RUN when mem_ready; wait_cnt<=0. On the release cycle, priorities 2-4 apply normally.
  - MEM_WAIT stays in MEM_WAIT when ~mem_ready; wait_cnt increments.
  - MEM_WAIT to ERROR when ~mem_ready & wait_cnt==MEM_TIMEOUT; mem_timeout<=1.
  - ERROR is absorbing until rst. Outputs in ERROR: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1, ex_mem_hold=1. Counters freeze.
- Counters:
  - stall_cnt increments on every cycle where priority 1 or 3 is active (RUN or MEM_WAIT).
  - flush_cnt increments on every priority-2 cycle.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Latency: zero-cycle combinational control, with registered state only. No output depends combinationally on the counters.

Test Plan:
- Reset: rst=1 mid-run with stall_cnt=7 -> immediately state=0, stall_cnt=0, if_id_flush=1, id_ex_bubble=1, pc_write=0.
- Load-use: ex_valid=1, ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1, stall_cnt 0->1. Repeat with ex_rd=0 -> no stall.
- Branch: ex_branch_taken=1 together with a load-use match -> if_id_flush=1, id_ex_bubble=1, pc_write=1, flush_cnt=1, stall_cnt unchanged.
- Memory wait: mem_req=1 with mem_ready low for 3 cycles, then high -> ex_mem_hold=1 for 3 cycles, state=1, stall_cnt=3, then state=0 and normal enables on the ready cycle.
- Memory wait with branch: ex_branch_taken=1 throughout a 2-cycle wait -> no flush during the wait; flush asserted on the mem_ready cycle, flush_cnt=1.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_timeout=1 and state=2 after cycle 5. Holds persist after mem_ready=1 until rst clears them.
